// File: rtl/ie_wb_stage.sv
// ie_wb_stage: consumer end of the issue-to-execute register.
// Evaluates the condition code against the architectural NZCV flags, arbitrates
// the single register-file write port between E results, a one-entry holding
// buffer (HB) and memory returns, and generates EN_E back-pressure.
// Optional feature macro: IE_WB_STALL_CNT_EN adds a saturating StallCnt output.
module ie_wb_stage #(
  parameter int DW = 32,
  parameter int IW = 3
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          ExecE,
  input  logic [3:0]    CondE,
  input  logic          RegWE,
  input  logic [IW-1:0] WIndexE,
  input  logic [DW-1:0] ALUResultE,
  input  logic          FlagWE,
  input  logic [3:0]    FlagsE,
  input  logic          MemRetValid,
  input  logic [IW-1:0] MemRetIndex,
  input  logic [DW-1:0] MemRetData,
  input  logic [IW-1:0] RdA,
  output logic          EN_E,
  output logic          CondExE,
  output logic [3:0]    FlagsW,
  output logic          RegWriteW,
  output logic [IW-1:0] WIndexW,
  output logic [DW-1:0] WDataW,
  output logic          FwdValidA,
  output logic [DW-1:0] FwdDataA
`ifdef IE_WB_STALL_CNT_EN
  ,
  output logic [15:0]   StallCnt
`endif
);

  logic [3:0]    r_flags;
  logic          r_wr;
  logic [IW-1:0] r_widx;
  logic [DW-1:0] r_wdata;
  logic          r_hb_valid;
  logic [IW-1:0] r_hb_idx;
  logic [DW-1:0] r_hb_data;

  logic w_n, w_z, w_c, w_v;
  logic w_pass;
  logic w_req;
  logic w_accept;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition code evaluation against architectural flags
  always_comb begin
    w_pass = 1'b0;
    case (CondE)
      4'd0:  w_pass = w_z;
      4'd1:  w_pass = !w_z;
      4'd2:  w_pass = w_c;
      4'd3:  w_pass = !w_c;
      4'd4:  w_pass = w_n;
      4'd5:  w_pass = !w_n;
      4'd6:  w_pass = w_v;
      4'd7:  w_pass = !w_v;
      4'd8:  w_pass = w_c & !w_z;
      4'd9:  w_pass = !w_c | w_z;
      4'd10: w_pass = (w_n == w_v);
      4'd11: w_pass = (w_n != w_v);
      4'd12: w_pass = !w_z & (w_n == w_v);
      4'd13: w_pass = w_z | (w_n != w_v);
      4'd14: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  assign CondExE  = ExecE & w_pass;
  // Request is deliberately not gated by EN_E so the stall has no comb loop
  assign w_req    = CondExE & RegWE;
  assign EN_E     = !(r_hb_valid & MemRetValid & w_req);
  assign w_accept = EN_E;

  assign FlagsW    = r_flags;
  assign RegWriteW = r_wr;
  assign WIndexW   = r_widx;
  assign WDataW    = r_wdata;

  // Architectural flag update for accepted, condition-passing instructions
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_flags <= '0;
    end else if (w_accept & CondExE & FlagWE) begin
      r_flags <= FlagsE;
    end
  end

  // Write-port arbitration: memory return, then HB, then direct E result.
  // HB holds the E result displaced by a memory return; when HB drains, a
  // same-cycle E request takes its place so program order is kept.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_wr       <= 1'b0;
      r_widx     <= '0;
      r_wdata    <= '0;
      r_hb_valid <= 1'b0;
      r_hb_idx   <= '0;
      r_hb_data  <= '0;
    end else if (MemRetValid) begin
      r_wr    <= 1'b1;
      r_widx  <= MemRetIndex;
      r_wdata <= MemRetData;
      if (w_req & w_accept) begin
        r_hb_valid <= 1'b1;
        r_hb_idx   <= WIndexE;
        r_hb_data  <= ALUResultE;
      end
    end else if (r_hb_valid) begin
      r_wr       <= 1'b1;
      r_widx     <= r_hb_idx;
      r_wdata    <= r_hb_data;
      r_hb_valid <= w_req;
      if (w_req) begin
        r_hb_idx  <= WIndexE;
        r_hb_data <= ALUResultE;
      end
    end else if (w_req) begin
      r_wr    <= 1'b1;
      r_widx  <= WIndexE;
      r_wdata <= ALUResultE;
    end else begin
      r_wr <= 1'b0;
    end
  end

  // Forwarding lookup: HB is newer than the W-stage write, so it wins
  always_comb begin
    FwdValidA = 1'b0;
    FwdDataA  = '0;
    if (r_hb_valid && (r_hb_idx == RdA)) begin
      FwdValidA = 1'b1;
      FwdDataA  = r_hb_data;
    end else if (r_wr && (r_widx == RdA)) begin
      FwdValidA = 1'b1;
      FwdDataA  = r_wdata;
    end
  end

`ifdef IE_WB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of stall cycles
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_stall_cnt <= '0;
    end else if (!EN_E && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ie_wb_stage.sv
// Testbench for ie_wb_stage: condition-code table, directed multi-cycle
// sequences and randomized traffic, all checked against a queue-based model.
module tb_ie_wb_stage;

  logic        CLK;
  logic        Reset;
  logic        ExecE;
  logic [3:0]  CondE;
  logic        RegWE;
  logic [2:0]  WIndexE;
  logic [31:0] ALUResultE;
  logic        FlagWE;
  logic [3:0]  FlagsE;
  logic        MemRetValid;
  logic [2:0]  MemRetIndex;
  logic [31:0] MemRetData;
  logic [2:0]  RdA;
  logic        EN_E;
  logic        CondExE;
  logic [3:0]  FlagsW;
  logic        RegWriteW;
  logic [2:0]  WIndexW;
  logic [31:0] WDataW;
  logic        FwdValidA;
  logic [31:0] FwdDataA;
`ifdef IE_WB_STALL_CNT_EN
  logic [15:0] StallCnt;
`endif

  ie_wb_stage #(.DW(32), .IW(3)) dut (
    .CLK(CLK), .Reset(Reset), .ExecE(ExecE), .CondE(CondE), .RegWE(RegWE),
    .WIndexE(WIndexE), .ALUResultE(ALUResultE), .FlagWE(FlagWE), .FlagsE(FlagsE),
    .MemRetValid(MemRetValid), .MemRetIndex(MemRetIndex), .MemRetData(MemRetData),
    .RdA(RdA), .EN_E(EN_E), .CondExE(CondExE), .FlagsW(FlagsW),
    .RegWriteW(RegWriteW), .WIndexW(WIndexW), .WDataW(WDataW),
    .FwdValidA(FwdValidA), .FwdDataA(FwdDataA)
`ifdef IE_WB_STALL_CNT_EN
    , .StallCnt(StallCnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        exec;
    logic [3:0]  cond;
    logic        regwe;
    logic [2:0]  widx;
    logic [31:0] res;
    logic        flagwe;
    logic [3:0]  flags;
    logic        mrv;
    logic [2:0]  mri;
    logic [31:0] mrd;
    logic [2:0]  rda;
  } in_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       pass;
  } cc_vec_t;

  int unsigned n_chk;
  int unsigned n_fail;

  // Reference model state: architectural flags, pending (buffered) writes,
  // and the write visible on the W port after the next edge.
  logic [3:0]  m_flags;
  wr_t         m_pend[$];
  logic        m_rw;
  logic [2:0]  m_widx;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition rules: base test chosen by cond[3:1], inverted by cond[0]
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic in_t idle();
    in_t v;
    v.exec = 0; v.cond = 4'd14; v.regwe = 0; v.widx = 0; v.res = 0;
    v.flagwe = 0; v.flags = 0; v.mrv = 0; v.mri = 0; v.mrd = 0; v.rda = 0;
    return v;
  endfunction

  function automatic in_t ereq(input logic [3:0] c, input logic [2:0] i, input logic [31:0] d);
    in_t v;
    v = idle();
    v.exec = 1; v.cond = c; v.regwe = 1; v.widx = i; v.res = d;
    return v;
  endfunction

  task automatic drive(input in_t v);
    ExecE = v.exec; CondE = v.cond; RegWE = v.regwe; WIndexE = v.widx;
    ALUResultE = v.res; FlagWE = v.flagwe; FlagsE = v.flags;
    MemRetValid = v.mrv; MemRetIndex = v.mri; MemRetData = v.mrd; RdA = v.rda;
  endtask

  // One clock cycle: check registered outputs from the previous edge, apply
  // inputs, check combinational outputs, then advance the model.
  task automatic cyc(input in_t v);
    wr_t lst[$];
    wr_t w;
    logic pass, cx, req, en, fv;
    logic [31:0] fd;
    @(negedge CLK);
    chk("RegWriteW", 32'(RegWriteW), 32'(m_rw));
    chk("WIndexW", 32'(WIndexW), 32'(m_widx));
    chk("WDataW", WDataW, m_wdata);
    chk("FlagsW", 32'(FlagsW), 32'(m_flags));
    drive(v);
    #1;
    pass = cond_pass(v.cond, m_flags);
    cx   = v.exec && pass;
    req  = cx && v.regwe;
    if (v.mrv) begin
      w.idx = v.mri; w.data = v.mrd; lst.push_back(w);
    end
    foreach (m_pend[k]) lst.push_back(m_pend[k]);
    if (req) begin
      w.idx = v.widx; w.data = v.res; lst.push_back(w);
    end
    // One write leaves per cycle and at most one may wait behind it
    en = (lst.size() <= 2);
    if (!en) void'(lst.pop_back());
    fv = 1'b0; fd = '0;
    for (int k = m_pend.size() - 1; k >= 0; k--) begin
      if (!fv && m_pend[k].idx == v.rda) begin
        fv = 1'b1; fd = m_pend[k].data;
      end
    end
    if (!fv && m_rw && m_widx == v.rda) begin
      fv = 1'b1; fd = m_wdata;
    end
    chk("EN_E", 32'(EN_E), 32'(en));
    chk("CondExE", 32'(CondExE), 32'(cx));
    chk("FwdValidA", 32'(FwdValidA), 32'(fv));
    chk("FwdDataA", FwdDataA, fd);
    if (en && cx && v.flagwe) m_flags = v.flags;
    if (lst.size() > 0) begin
      w = lst.pop_front();
      m_rw = 1'b1; m_widx = w.idx; m_wdata = w.data;
    end else begin
      m_rw = 1'b0;
    end
    m_pend = lst;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b0;
    drive(idle());
    #1;
    chk("rst_RegWriteW", 32'(RegWriteW), 0);
    chk("rst_WIndexW", 32'(WIndexW), 0);
    chk("rst_WDataW", WDataW, 0);
    chk("rst_FlagsW", 32'(FlagsW), 0);
    chk("rst_EN_E", 32'(EN_E), 1);
    chk("rst_FwdValidA", 32'(FwdValidA), 0);
    m_flags = '0; m_pend.delete(); m_rw = 0; m_widx = '0; m_wdata = '0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    in_t v;
    v = idle();
    v.exec = 1; v.cond = 4'd14; v.flagwe = 1; v.flags = f;
    cyc(v);
  endtask

  cc_vec_t cc_tab[18];

  initial begin
    in_t v;
    n_chk = 0; n_fail = 0;
    Reset = 1'b0;
    drive(idle());
    m_flags = '0; m_rw = 0; m_widx = '0; m_wdata = '0;

    cc_tab[0]  = '{4'b0100, 4'd0,  1'b1};
    cc_tab[1]  = '{4'b0100, 4'd1,  1'b0};
    cc_tab[2]  = '{4'b0010, 4'd2,  1'b1};
    cc_tab[3]  = '{4'b0010, 4'd3,  1'b0};
    cc_tab[4]  = '{4'b1000, 4'd4,  1'b1};
    cc_tab[5]  = '{4'b1000, 4'd5,  1'b0};
    cc_tab[6]  = '{4'b0001, 4'd6,  1'b1};
    cc_tab[7]  = '{4'b0000, 4'd7,  1'b1};
    cc_tab[8]  = '{4'b0010, 4'd8,  1'b1};
    cc_tab[9]  = '{4'b0110, 4'd8,  1'b0};
    cc_tab[10] = '{4'b0000, 4'd9,  1'b1};
    cc_tab[11] = '{4'b1001, 4'd10, 1'b1};
    cc_tab[12] = '{4'b1000, 4'd11, 1'b1};
    cc_tab[13] = '{4'b0000, 4'd12, 1'b1};
    cc_tab[14] = '{4'b0100, 4'd12, 1'b0};
    cc_tab[15] = '{4'b0001, 4'd13, 1'b1};
    cc_tab[16] = '{4'b0000, 4'd14, 1'b1};
    cc_tab[17] = '{4'b1111, 4'd15, 1'b0};

    do_reset();

    // Condition-code table
    for (int unsigned i = 0; i < 18; i++) begin
      set_flags(cc_tab[i].flags);
      v = idle();
      v.exec = 1; v.cond = cc_tab[i].cond;
      cyc(v);
      chk("cc_table", 32'(CondExE), 32'(cc_tab[i].pass));
    end

    // EQ passes with Z set and writes; NE fails and does not
    set_flags(4'b0100);
    cyc(ereq(4'd0, 3'd3, 32'h55));
    chk("eq_condex", 32'(CondExE), 1);
    cyc(idle());
    chk("eq_wr", 32'(RegWriteW), 1);
    chk("eq_idx", 32'(WIndexW), 3);
    chk("eq_data", WDataW, 32'h55);
    cyc(ereq(4'd1, 3'd3, 32'h66));
    chk("ne_condex", 32'(CondExE), 0);
    cyc(idle());
    chk("ne_nowr", 32'(RegWriteW), 0);

    // Memory return and E request to the same index in one cycle
    v = ereq(4'd14, 3'd2, 32'hBB);
    v.mrv = 1; v.mri = 3'd2; v.mrd = 32'hAA;
    cyc(v);
    chk("col_en", 32'(EN_E), 1);
    cyc(idle());
    chk("col_en1", 32'(EN_E), 1);
    chk("col_w1", WDataW, 32'hAA);
    cyc(idle());
    chk("col_w2", WDataW, 32'hBB);
    chk("col_w2idx", 32'(WIndexW), 2);

    // Stall: HB full, memory return and E request together
    set_flags(4'b0000);
    v = ereq(4'd14, 3'd5, 32'h5);
    v.mrv = 1; v.mri = 3'd1; v.mrd = 32'h1;
    cyc(v);
    v = ereq(4'd14, 3'd7, 32'h7);
    v.flagwe = 1; v.flags = 4'hA;
    v.mrv = 1; v.mri = 3'd6; v.mrd = 32'h6;
    cyc(v);
    chk("stall_en", 32'(EN_E), 0);
    v.mrv = 0;
    cyc(v);
    chk("stall_flags", 32'(FlagsW), 0);
    chk("stall_resume_en", 32'(EN_E), 1);
    cyc(idle());
    chk("stall_hb_idx", 32'(WIndexW), 5);
    chk("stall_flags_upd", 32'(FlagsW), 32'hA);
    cyc(idle());
    chk("stall_e_idx", 32'(WIndexW), 7);

    // Forwarding priority: HB beats W
    for (int unsigned r = 0; r < 2; r++) begin
      v = ereq(4'd14, 3'd4, 32'h11);
      v.mrv = 1; v.mri = 3'd4; v.mrd = 32'h22;
      cyc(v);
      v = idle();
      v.rda = (r == 0) ? 3'd4 : 3'd6;
      cyc(v);
      chk("fwd_valid", 32'(FwdValidA), (r == 0) ? 1 : 0);
      chk("fwd_data", FwdDataA, (r == 0) ? 32'h11 : 32'h0);
    end

    // Never-condition must not update flags; AL does
    set_flags(4'h3);
    v = idle();
    v.exec = 1; v.cond = 4'd15; v.flagwe = 1; v.flags = 4'hF;
    cyc(v);
    chk("nv_condex", 32'(CondExE), 0);
    v.cond = 4'd14;
    cyc(v);
    chk("nv_flags", 32'(FlagsW), 32'h3);
    cyc(idle());
    chk("al_flags", 32'(FlagsW), 32'hF);

    // Reset with HB full
    v = ereq(4'd14, 3'd5, 32'hC5);
    v.mrv = 1; v.mri = 3'd0; v.mrd = 32'hC0;
    cyc(v);
    do_reset();
    v = idle();
    v.rda = 3'd5;
    cyc(v);
    chk("rst_hb_gone", 32'(FwdValidA), 0);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        v.exec   = ($urandom_range(0, 3) != 0);
        v.cond   = 4'($urandom_range(0, 15));
        v.regwe  = ($urandom_range(0, 3) != 0);
        v.widx   = 3'($urandom_range(0, 7));
        v.res    = $urandom;
        v.flagwe = ($urandom_range(0, 2) == 0);
        v.flags  = 4'($urandom_range(0, 15));
        v.mrv    = ($urandom_range(0, 9) < 4);
        v.mri    = 3'($urandom_range(0, 7));
        v.mrd    = $urandom;
        v.rda    = 3'($urandom_range(0, 7));
        cyc(v);
      end
    end
    cyc(idle());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ie_wb_stage.md
Name: ie_wb_stage

Overview:
- Consumer end of the issue-to-execute register: takes the E-stage instruction fields and the E-stage ALU result.
- Evaluates the condition code against the architectural NZCV flags and arbitrates the single register-file write port between E results and memory returns.
- Drives the writeback (W) register and generates the EN back-pressure that the issue-to-execute register uses to hold its contents.

Parameters:
DW, 32, data width of results and forwarded data
IW, 3, register index width

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
ExecE  in  1  E-stage slot holds a real instruction
CondE  in  4  condition code
RegWE  in  1  instruction writes a register
WIndexE  in  IW  destination index
ALUResultE  in  DW  result to write
FlagWE  in  1  instruction updates flags
FlagsE  in  4  new NZCV {N,Z,C,V}
MemRetValid  in  1  memory return wants the write port this cycle
MemRetIndex  in  IW  memory return destination
MemRetData  in  DW  memory return data
RdA  in  IW  forwarding lookup index
EN_E  out  1  enable to issue-to-execute register; 0 = hold (stall)
CondExE  out  1  combinational: ExecE and condition passes
FlagsW  out  4  architectural NZCV
RegWriteW  out  1  register-file write strobe
WIndexW  out  IW  write index
WDataW  out  DW  write data
FwdValidA  out  1  RdA matches a pending or W-stage write
FwdDataA  out  DW  forwarded data

Behaviour:

Reset (Reset=0, async):
- FlagsW=0, RegWriteW=0, WIndexW=0, WDataW=0, holding buffer HB invalid.
- Outputs while in reset: EN_E=1, FwdValidA=0.
- Reset mid-operation discards HB and any pending write.

Condition pass, evaluated against FlagsW:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
- 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
- 14 AL 1; 15 never 0.
- CondExE = ExecE & pass.

Write request:
- ReqE = CondExE & RegWE. It is not gated by EN_E, so no combinational loop.

Stall:
- EN_E = !(HB.valid & MemRetValid & ReqE).
- Accept = EN_E, i.e. the E instruction is consumed this cycle.
- When not accepted: flags unchanged; E request neither buffered nor written.

Flags:
- On posedge, FlagsW <= FlagsE when Accept & CondExE & FlagWE.
- Flag-only instructions (RegWE=0) never stall.

Write-port source select, one per cycle, in priority order:
1. MemRetValid: write MemRet. An accepted ReqE goes into HB (HB empty by the stall rule).
2. HB.valid: write HB. If ReqE is accepted it refills HB in the same cycle; otherwise HB is cleared.
3. ReqE: write E result directly.
4. Otherwise RegWriteW <= 0; WIndexW/WDataW hold their previous values.

Ordering and latency:
- Latency: a selected source appears on RegWriteW/WIndexW/WDataW the next cycle, for one cycle.
- Program order: HB is always newer than any concurrent memory return and older than the current E instruction.
- Same-index collisions resolve by the write order above; writes never coalesce.

Forwarding (combinational):
- HB.valid & HB.idx==RdA: FwdDataA=HB.data.
- Else RegWriteW & WIndexW==RdA: FwdDataA=WDataW.
- Else FwdValidA=0, FwdDataA=0.

HB capacity:
- One entry; never overwritten while valid unless drained in the same cycle.

Optional Feature:
IE_WB_STALL_CNT_EN:
- Defined: adds output StallCnt[15:0]. It increments each cycle EN_E=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. Reset low mid-run with HB full -> next cycle HB empty, RegWriteW=0, FlagsW=0, EN_E=1.
2. FlagsW=4'b0100 (Z=1), CondE=0 EQ, RegWE=1, WIndexE=3, ALUResultE=32'h55 -> CondExE=1; next cycle RegWriteW=1, WIndexW=3, WDataW=32'h55. Same with CondE=1 NE -> CondExE=0, no write.
3. MemRetValid=1 (idx 2, 32'hAA) and ReqE (idx 2, 32'hBB) same cycle -> cycle+1 writes idx2=AA; cycle+2 writes idx2=BB; EN_E=1 throughout.
4. HB full (idx 5), MemRetValid=1, ReqE=1 -> EN_E=0 and flags unchanged. Next cycle with MemRetValid=0 -> HB written, E accepted into HB, EN_E=1.
5. HB holds idx4=32'h11 and W holds idx4=32'h22, RdA=4 -> FwdValidA=1, FwdDataA=32'h11. RdA=6 -> FwdValidA=0.
6. CondE=15, FlagWE=1, FlagsE=4'hF -> CondExE=0, FlagsW unchanged. CondE=14 -> FlagsW=4'hF next cycle.
